// File: rtl/dmem_pkg.sv
// Shared types and the address-fault decode for the data-side memory slave.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WAIT_W = 4;

    // Misaligned, below the window, or past the last word.
    function automatic logic dmem_fault(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned depth);
        logic [31:0] off;
        off = addr - base;
        return (addr < base) || ((off >> 2) >= depth) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte write enables and a registered read port.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [3:0]    we_i,
    input  logic          re_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read data is only non-zero for the one cycle following a read strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= re_i ? mem_q[idx_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_slave.sv
// Data-side memory slave: one request at a time, programmable wait states,
// byte-strobed stores, registered loads and access-fault reporting.
module data_mem_slave
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              ready_q, err_q, err_d;

    logic [31:0]       req_addr, req_wdata;
    logic [3:0]        req_wstrb, arr_we;
    logic [AW-1:0]     req_idx;
    logic              req_fault, commit, arr_re;

    // With zero wait states the commit edge is the accept edge, so decode
    // straight from the inputs while idle.
    always_comb begin
        req_addr  = (state_q == IDLE) ? mem_addr_i  : addr_q;
        req_wdata = (state_q == IDLE) ? mem_wdata_i : wdata_q;
        req_wstrb = (state_q == IDLE) ? mem_wstrb_i : wstrb_q;
        req_fault = dmem_fault(req_addr, BASE_ADDR, DEPTH_WORDS);
        req_idx   = AW'((req_addr - BASE_ADDR) >> 2);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wstrb_d = mem_wstrb_i;
                    cnt_d   = WAIT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        commit = (state_d == RESP) && (state_q != RESP);
        arr_we = (commit && !req_fault) ? req_wstrb : 4'b0000;
        arr_re = commit && !req_fault && (req_wstrb == 4'b0000);
        err_d  = commit && req_fault;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= commit;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .idx_i  (req_idx),
        .wdata_i(req_wdata),
        .rdata_o(mem_rdata_o)
    );

    assign mem_ready_o = ready_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_slave.sv
// Scoreboard bench: three slaves with 2, 0 and 3 wait states against a
// byte-level reference memory; responses are checked by a separate monitor.
module tb_data_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  valid;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [2:0]  ready, err, busy;
    logic [31:0] rdata [3];

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        int          cyc;
        logic        err;
        logic [31:0] rd;
        logic [31:0] mask;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          act_inst = -1;
    int          acc_cyc = 1;
    int          resp_cyc = 0;
    bit          resp_seen = 0;
    int          wc[3] = '{2, 0, 3};
    logic [31:0] mdl   [int];
    logic [3:0]  mdl_m [int];

    data_mem_slave #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000), .WAIT_CYCLES(2)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid[0]), .mem_addr_i(addr[0]),
        .mem_wdata_i(wdata[0]), .mem_wstrb_i(wstrb[0]), .mem_ready_o(ready[0]),
        .mem_rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0]));

    data_mem_slave #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid[1]), .mem_addr_i(addr[1]),
        .mem_wdata_i(wdata[1]), .mem_wstrb_i(wstrb[1]), .mem_ready_o(ready[1]),
        .mem_rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1]));

    data_mem_slave #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000), .WAIT_CYCLES(3)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid[2]), .mem_addr_i(addr[2]),
        .mem_wdata_i(wdata[2]), .mem_wstrb_i(wstrb[2]), .mem_ready_o(ready[2]),
        .mem_rdata_o(rdata[2]), .err_o(err[2]), .busy_o(busy[2]));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    function automatic bit ref_fault(input logic [31:0] a);
        return (a < 32'h1000) || (a >= 32'h1000 + 256 * 4) || (a % 4 != 0);
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk("busy", 32'(busy[i]),
                    32'(i == act_inst && cyc >= acc_cyc && cyc <= resp_cyc));
                if (ready[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_ready", 32'(ready[i]), 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("ready_inst", i, mon_e.inst);
                        chk("latency", cyc, mon_e.cyc);
                        chk("err", 32'(err[i]), 32'(mon_e.err));
                        if (mon_e.mask != 0)
                            chk("rdata", rdata[i] & mon_e.mask, mon_e.rd & mon_e.mask);
                        resp_seen = 1;
                    end
                end else begin
                    chk("idle_rdata", rdata[i], 32'd0);
                    chk("idle_err", 32'(err[i]), 32'd0);
                end
            end
        end
    end

    // Called one step after a rising edge, in a cycle where the target is idle.
    task automatic issue(input int inst, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit drop);
        exp_t        e;
        int          key, n;
        logic [31:0] w;
        logic [3:0]  m;
        e.inst = inst;
        e.cyc  = cyc + 1 + wc[inst];
        e.err  = ref_fault(a);
        e.rd   = 32'd0;
        e.mask = 32'hFFFF_FFFF;
        if (!e.err) begin
            key = inst * 256 + int'((a - 32'h1000) / 4);
            w = mdl.exists(key) ? mdl[key] : 32'd0;
            m = mdl_m.exists(key) ? mdl_m[key] : 4'b0000;
            if (s == 4'b0000) begin
                e.rd   = w;
                e.mask = byte_mask(m);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) w[8*b +: 8] = d[8*b +: 8];
                mdl[key]   = w;
                mdl_m[key] = m | s;
            end
        end
        exp_q.push_back(e);
        act_inst  = inst;
        acc_cyc   = cyc + 1;
        resp_cyc  = cyc + 1 + wc[inst];
        resp_seen = 0;
        valid       = '0;
        valid[inst] = 1'b1;
        addr[inst]  = a;
        wdata[inst] = d;
        wstrb[inst] = s;
        if (drop) begin
            @(posedge clk); #1;
            valid[inst] = 1'b0;
            addr[inst]  = $urandom;
            wdata[inst] = $urandom;
            wstrb[inst] = 4'($urandom);
        end
        n = 0;
        while (!resp_seen && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!resp_seen) chk("ready_timeout", 32'(resp_seen), 32'd1);
    endtask

    task automatic release_bus();
        valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_ready"}, 32'(ready[i]), 32'd0);
            chk({tag, "_rdata"}, rdata[i], 32'd0);
            chk({tag, "_err"}, 32'(err[i]), 32'd0);
            chk({tag, "_busy"}, 32'(busy[i]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          inst, sel;
        logic [31:0] a;
        logic [3:0]  s;
        valid = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known word at 0x1000, then abort an overwrite with reset mid-wait.
        issue(0, 32'h1000, 32'hCAFE_F00D, 4'hF, 0);
        release_bus();
        act_inst  = 0;
        acc_cyc   = cyc + 1;
        resp_cyc  = cyc + 3;
        valid[0]  = 1'b1;
        addr[0]   = 32'h1000;
        wdata[0]  = 32'h1234_5678;
        wstrb[0]  = 4'hF;
        @(posedge clk); #1;
        valid    = '0;
        rst_n    = 1'b0;
        act_inst = -1;
        #1;
        check_quiet("abort");
        @(posedge clk); #1;
        check_quiet("abort_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, 32'h1000, 32'h0, 4'h0, 0);
        release_bus();

        // Full word, byte strobes, faults.
        issue(0, 32'h1004, 32'hDEAD_BEEF, 4'hF, 0);   release_bus();
        issue(0, 32'h1004, 32'h0, 4'h0, 0);           release_bus();
        issue(0, 32'h1004, 32'h1122_3344, 4'b0101, 0); release_bus();
        issue(0, 32'h1004, 32'h0, 4'h0, 0);           release_bus();
        issue(0, 32'h1002, 32'h0, 4'h0, 0);           release_bus();
        issue(0, 32'h0FFC, 32'h0, 4'h0, 0);           release_bus();
        issue(0, 32'h1400, 32'hAAAA_5555, 4'hF, 0);   release_bus();
        issue(0, 32'h1004, 32'h0, 4'h0, 0);           release_bus();

        // Zero wait states; valid dropped right after acceptance.
        issue(1, 32'h1010, 32'h0BAD_F00D, 4'hF, 0);   release_bus();
        issue(1, 32'h1010, 32'h0, 4'h0, 0);           release_bus();
        issue(2, 32'h1020, 32'hA5A5_5A5A, 4'hF, 1);   release_bus();
        issue(2, 32'h1020, 32'h0, 4'h0, 1);           release_bus();

        // Valid held across the response: second request follows.
        issue(0, 32'h1008, 32'h0BAD_C0DE, 4'hF, 0);
        issue(0, 32'h1008, 32'h0, 4'h0, 0);
        release_bus();

        for (int t = 0; t < 200; t++) begin
            inst = $urandom_range(0, 2);
            sel  = $urandom_range(0, 9);
            case (sel)
                0: a = 32'h1000 + 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
                1: a = 32'h1000 - 4 * $urandom_range(1, 64);
                2: a = 32'h1400 + 4 * $urandom_range(0, 64);
                default: a = 32'h1000 + 4 * $urandom_range(0, 15);
            endcase
            s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            issue(inst, a, $urandom, s, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) release_bus();
        end
        release_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
